lc4_branch_predictor: RTL and testbench

Parametrised branch resolution and prediction unit for the out-of-order LC4 core. Fetch gets a same-cycle combinational taken/target prediction from a direct-mapped, tagged BTB with saturating counters. Execute resolves each control instruction from NZP flags and the instruction's condition bits, trains the table, and issues a registered one-cycle redirect on misprediction. Two saturating performance counters track resolved branches and mispredictions.

---
 rtl/lc4_bp_if.sv | 37 +++
 rtl/lc4_branch_predictor.sv | 126 ++++++++++++
 tb/tb_lc4_branch_predictor.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc4_bp_if.sv
// Fetch/resolve bus between the LC4 pipeline and the branch predictor.
// master = pipeline side (drives fetch PC and resolutions),
// slave  = predictor side (returns prediction, redirect and counters).
interface lc4_bp_if #(
  parameter int CNT_W = 32
);
  logic [15:0]      fetch_pc;
  logic             pred_taken;
  logic [15:0]      pred_tgt;
  logic             res_valid;
  logic [15:0]      res_pc;
  logic [15:0]      res_tgt;
  logic [2:0]       res_cond;
  logic [2:0]       res_nzp;
  logic             res_is_branch;
  logic             res_is_control;
  logic             res_pred_taken;
  logic [15:0]      res_pred_tgt;
  logic             mispredict;
  logic [15:0]      redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output fetch_pc, res_valid, res_pc, res_tgt, res_cond, res_nzp,
           res_is_branch, res_is_control, res_pred_taken, res_pred_tgt,
    input  pred_taken, pred_tgt, mispredict, redirect_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  fetch_pc, res_valid, res_pc, res_tgt, res_cond, res_nzp,
           res_is_branch, res_is_control, res_pred_taken, res_pred_tgt,
    output pred_taken, pred_tgt, mispredict, redirect_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/lc4_branch_predictor.sv
// LC4 branch predictor: direct-mapped tagged BTB with saturating counters,
// same-cycle fetch prediction, resolution/training at execute, registered
// one-cycle redirect on misprediction, and two saturating perf counters.
module lc4_branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32
) (
  input logic   clk,
  input logic   rst_n,
  lc4_bp_if.slave bp
);

  localparam int TAG_W = 16 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_MAX >> 1;  // 0111..1
  localparam logic [CTR_W-1:0] CTR_WT  = ~CTR_WNT;      // 1000..0
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [15:0]      tgt_q   [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];

  logic             mispredict_q;
  logic [15:0]      redirect_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  // Lookup side
  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_hit;
  logic             fetch_taken;

  // Resolution side
  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] res_tag;
  logic             res_hit;
  logic             uncond;
  logic             taken;
  logic [15:0]      actual_next;
  logic             mispred;
  logic             ctr_we;
  logic [CTR_W-1:0] ctr_next;
  logic             tag_we;
  logic             tgt_we;

  // Zero-latency prediction from current table state (pre-update on collision)
  always_comb begin
    fetch_idx   = bp.fetch_pc[IDX_W-1:0];
    fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == bp.fetch_pc[15:IDX_W]);
    fetch_taken = fetch_hit && ctr_q[fetch_idx][CTR_W-1];
  end

  assign bp.pred_taken = fetch_taken;
  assign bp.pred_tgt   = fetch_taken ? tgt_q[fetch_idx] : bp.fetch_pc + 16'd1;

  // Resolve direction, detect misprediction and decide how to train the entry
  always_comb begin
    res_idx     = bp.res_pc[IDX_W-1:0];
    res_tag     = bp.res_pc[15:IDX_W];
    res_hit     = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
    uncond      = !bp.res_is_branch && bp.res_is_control;
    taken       = bp.res_is_branch ? |(bp.res_nzp & bp.res_cond) : bp.res_is_control;
    actual_next = taken ? bp.res_tgt : bp.res_pc + 16'd1;
    mispred     = bp.res_valid &&
                  ((bp.res_pred_taken != taken) || (taken && (bp.res_pred_tgt != bp.res_tgt)));

    // Unconditional control always implies taken, so it shares the taken paths.
    tag_we = bp.res_valid && (uncond || (!res_hit && taken));
    tgt_we = bp.res_valid && taken;
    ctr_we = bp.res_valid && (uncond || res_hit || taken);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    ctr_next = ctr_q[res_idx];
    if (uncond) begin
      ctr_next = CTR_MAX;
    end else if (res_hit) begin
      if (taken && ctr_q[res_idx] != CTR_MAX) begin
        ctr_next = ctr_q[res_idx] + CTR_W'(1);
      end else if (!taken && ctr_q[res_idx] != '0) begin
        ctr_next = ctr_q[res_idx] - CTR_W'(1);
      end
    end else begin
      ctr_next = CTR_WT;
    end
  end

  // Resettable state: valid bits, counters, redirect pulse and perf counters
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
      mispredict_q  <= 1'b0;
      redirect_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      mispredict_q <= mispred;
      if (mispred) redirect_q <= actual_next;
      if (tag_we) valid_q[res_idx] <= 1'b1;
      if (ctr_we) ctr_q[res_idx] <= ctr_next;
      if (bp.res_valid && branch_cnt_q != CNT_MAX) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (mispred && mispred_cnt_q != CNT_MAX) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  // Tag/target payload: no reset, since valid gates every use of it
  always_ff @(posedge clk) begin
    // NOTE: tags and targets are left unreset; clearing valid is enough and keeps them plain RAM.
    if (rst_n) begin
      if (tag_we) tag_q[res_idx] <= res_tag;
      if (tgt_we) tgt_q[res_idx] <= bp.res_tgt;
    end
  end

  assign bp.mispredict       = mispredict_q;
  assign bp.redirect_pc      = redirect_q;
  assign bp.branch_count     = branch_cnt_q;
  assign bp.mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_lc4_branch_predictor.sv
// Self-checking bench for lc4_branch_predictor: directed scenarios followed
// by randomized traffic compared against an array-based reference model.
module tb_lc4_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int CTR_W   = 2;
  localparam int CNT_W   = 32;
  localparam int CMAX    = (1 << CTR_W) - 1;
  localparam int CHALF   = 1 << (CTR_W - 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lc4_bp_if #(.CNT_W(CNT_W)) bp ();

  lc4_branch_predictor #(
    .ENTRIES(ENTRIES),
    .CTR_W  (CTR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bp   (bp)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per-index records with integer counters
  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  int          m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_misp;
  int          m_redir;
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  function automatic bit m_pred_taken(input int pc);
    int idx = pc % ENTRIES;
    return m_valid[idx] && (m_tag[idx] == pc / ENTRIES) && (m_ctr[idx] >= CHALF);
  endfunction

  function automatic int m_pred_tgt(input int pc);
    return m_pred_taken(pc) ? m_tgt[pc % ENTRIES] : (pc + 1) % 65536;
  endfunction

  task automatic model_update();
    int pc, tgt, idx, nxt;
    bit tk, hit, mp;
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = CHALF - 1;
      end
      m_misp = 1'b0; m_redir = 0; m_bc = '0; m_mc = '0;
      return;
    end
    mp = 1'b0;
    if (bp.res_valid) begin
      pc  = int'(bp.res_pc);
      tgt = int'(bp.res_tgt);
      tk  = bp.res_is_branch ? ((bp.res_nzp & bp.res_cond) != 3'b000) : bp.res_is_control;
      nxt = tk ? tgt : (pc + 1) % 65536;
      mp  = (bp.res_pred_taken != tk) || (tk && int'(bp.res_pred_tgt) != tgt);
      idx = pc % ENTRIES;
      hit = m_valid[idx] && (m_tag[idx] == pc / ENTRIES);
      if (!bp.res_is_branch && bp.res_is_control) begin
        m_valid[idx] = 1'b1; m_tag[idx] = pc / ENTRIES; m_tgt[idx] = tgt; m_ctr[idx] = CMAX;
      end else if (hit) begin
        m_ctr[idx] = tk ? ((m_ctr[idx] < CMAX) ? m_ctr[idx] + 1 : CMAX)
                        : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
        if (tk) m_tgt[idx] = tgt;
      end else if (tk) begin
        m_valid[idx] = 1'b1; m_tag[idx] = pc / ENTRIES; m_tgt[idx] = tgt; m_ctr[idx] = CHALF;
      end
      if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
      if (mp && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 32'd1;
      if (mp) m_redir = nxt;
    end
    m_misp = mp;
  endtask

  task automatic drive_res(input bit v, input int pc, input int tgt, input int cond,
                           input int nzp, input bit isb, input bit isc,
                           input bit pt, input int ptgt);
    bp.res_valid      = v;
    bp.res_pc         = 16'(pc);
    bp.res_tgt        = 16'(tgt);
    bp.res_cond       = 3'(cond);
    bp.res_nzp        = 3'(nzp);
    bp.res_is_branch  = isb;
    bp.res_is_control = isc;
    bp.res_pred_taken = pt;
    bp.res_pred_tgt   = 16'(ptgt);
  endtask

  task automatic idle_res();
    drive_res(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // One clock: model follows the DUT at the edge, sampling resumes at negedge
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_res();
    bp.fetch_pc = 16'h0040;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    total++; if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_taken got=%0b want=0", bp.pred_taken); end
    total++; if (bp.pred_tgt !== 16'h0041) begin bad++; $display("FAIL reset_pred_tgt got=%h want=0041", bp.pred_tgt); end
    total++; if (bp.mispredict !== 1'b0) begin bad++; $display("FAIL reset_mispredict got=%0b want=0", bp.mispredict); end
    total++; if (bp.branch_count !== 32'd0) begin bad++; $display("FAIL reset_branch_count got=%0d want=0", bp.branch_count); end
    total++; if (bp.mispredict_count !== 32'd0) begin bad++; $display("FAIL reset_mispredict_count got=%0d want=0", bp.mispredict_count); end
  endtask

  task automatic test_cold_branch();
    drive_res(1'b1, 'h0040, 'h0100, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 'h0041);
    tick();
    idle_res();
    bp.fetch_pc = 16'h0040;
    #1;
    total++; if (bp.mispredict !== 1'b1) begin bad++; $display("FAIL cold_mispredict got=%0b want=1", bp.mispredict); end
    total++; if (bp.redirect_pc !== 16'h0100) begin bad++; $display("FAIL cold_redirect got=%h want=0100", bp.redirect_pc); end
    total++; if (bp.mispredict_count !== 32'd1) begin bad++; $display("FAIL cold_mispredict_count got=%0d want=1", bp.mispredict_count); end
    total++; if (bp.pred_taken !== 1'b1) begin bad++; $display("FAIL cold_pred_taken got=%0b want=1", bp.pred_taken); end
    total++; if (bp.pred_tgt !== 16'h0100) begin bad++; $display("FAIL cold_pred_tgt got=%h want=0100", bp.pred_tgt); end
    tick();
    total++; if (bp.mispredict !== 1'b0) begin bad++; $display("FAIL cold_pulse_width got=%0b want=0", bp.mispredict); end
  endtask

  task automatic test_hysteresis();
    drive_res(1'b1, 'h0040, 'h0100, 3'b100, 3'b010, 1'b1, 1'b0, 1'b1, 'h0100);
    tick();
    idle_res();
    #1;
    total++; if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL hyst_first_nt got=%0b want=0", bp.pred_taken); end
    total++; if (bp.pred_tgt !== 16'h0041) begin bad++; $display("FAIL hyst_first_nt_tgt got=%h want=0041", bp.pred_tgt); end
    drive_res(1'b1, 'h0040, 'h0100, 3'b100, 3'b010, 1'b1, 1'b0, 1'b0, 'h0041);
    tick();
    drive_res(1'b1, 'h0040, 'h0100, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 'h0041);
    tick();
    idle_res();
    #1;
    total++; if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL hyst_floor_then_taken got=%0b want=0", bp.pred_taken); end
    total++; if (bp.mispredict_count !== 32'd3) begin bad++; $display("FAIL hyst_mispredict_count got=%0d want=3", bp.mispredict_count); end
  endtask

  task automatic test_jmp_alias();
    drive_res(1'b1, 'h0050, 'h2000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 'h0051);
    tick();
    idle_res();
    bp.fetch_pc = 16'h0040;
    #1;
    total++; if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL alias_miss_taken got=%0b want=0", bp.pred_taken); end
    total++; if (bp.pred_tgt !== 16'h0041) begin bad++; $display("FAIL alias_miss_tgt got=%h want=0041", bp.pred_tgt); end
    bp.fetch_pc = 16'h0050;
    #1;
    total++; if (bp.pred_taken !== 1'b1) begin bad++; $display("FAIL alias_jmp_taken got=%0b want=1", bp.pred_taken); end
    total++; if (bp.pred_tgt !== 16'h2000) begin bad++; $display("FAIL alias_jmp_tgt got=%h want=2000", bp.pred_tgt); end
  endtask

  task automatic test_wrap();
    bp.fetch_pc = 16'hFFFF;
    drive_res(1'b1, 'hFFFF, 'h1234, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 'h0000);
    #1;
    total++; if (bp.pred_tgt !== 16'h0000) begin bad++; $display("FAIL wrap_pred_tgt got=%h want=0000", bp.pred_tgt); end
    tick();
    total++; if (bp.mispredict !== 1'b0) begin bad++; $display("FAIL wrap_no_mispredict got=%0b want=0", bp.mispredict); end
    drive_res(1'b1, 'h0060, 'h0123, 3'b010, 3'b010, 1'b1, 1'b0, 1'b1, 'h0456);
    tick();
    idle_res();
    total++; if (bp.mispredict !== 1'b1) begin bad++; $display("FAIL wrong_tgt_mispredict got=%0b want=1", bp.mispredict); end
    total++; if (bp.redirect_pc !== 16'h0123) begin bad++; $display("FAIL wrong_tgt_redirect got=%h want=0123", bp.redirect_pc); end
  endtask

  task automatic test_same_cycle();
    bp.fetch_pc = 16'h0003;
    drive_res(1'b1, 'h0003, 'h0777, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 'h0004);
    #1;
    total++; if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL collide_old_taken got=%0b want=0", bp.pred_taken); end
    total++; if (bp.pred_tgt !== 16'h0004) begin bad++; $display("FAIL collide_old_tgt got=%h want=0004", bp.pred_tgt); end
    tick();
    idle_res();
    #1;
    total++; if (bp.pred_taken !== 1'b1) begin bad++; $display("FAIL collide_new_taken got=%0b want=1", bp.pred_taken); end
    total++; if (bp.pred_tgt !== 16'h0777) begin bad++; $display("FAIL collide_new_tgt got=%h want=0777", bp.pred_tgt); end
  endtask

  task automatic test_back_to_back();
    drive_res(1'b1, 'h0070, 'h1111, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 'h0071);
    tick();
    drive_res(1'b1, 'h0080, 'h2222, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 'h0081);
    total++; if (bp.mispredict !== 1'b1 || bp.redirect_pc !== 16'h1111) begin bad++; $display("FAIL b2b_first got=%0b/%h want=1/1111", bp.mispredict, bp.redirect_pc); end
    tick();
    idle_res();
    total++; if (bp.mispredict !== 1'b1 || bp.redirect_pc !== 16'h2222) begin bad++; $display("FAIL b2b_second got=%0b/%h want=1/2222", bp.mispredict, bp.redirect_pc); end
    tick();
    total++; if (bp.mispredict !== 1'b0) begin bad++; $display("FAIL b2b_end got=%0b want=0", bp.mispredict); end
  endtask

  task automatic test_reset_mid();
    drive_res(1'b1, 'h0090, 'h3333, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 'h0091);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle_res();
    bp.fetch_pc = 16'h0003;
    #1;
    total++; if (bp.mispredict !== 1'b0) begin bad++; $display("FAIL rstmid_mispredict got=%0b want=0", bp.mispredict); end
    total++; if (bp.branch_count !== 32'd0) begin bad++; $display("FAIL rstmid_branch_count got=%0d want=0", bp.branch_count); end
    total++; if (bp.mispredict_count !== 32'd0) begin bad++; $display("FAIL rstmid_mispredict_count got=%0d want=0", bp.mispredict_count); end
    total++; if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL rstmid_table_cleared got=%0b want=0", bp.pred_taken); end
  endtask

  function automatic int rand_pc();
    int up;
    case ($urandom_range(0, 3))
      0:       up = 'h000;
      1:       up = 'h001;
      2:       up = 'hABC;
      default: up = 'hFFF;
    endcase
    return (up << 4) | int'($urandom_range(0, 15));
  endfunction

  task automatic test_random();
    int rpc, rtgt, kind;
    bit pt;
    int ptgt;
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      bp.fetch_pc = 16'(rand_pc());
      rpc  = rand_pc();
      rtgt = ($urandom_range(0, 1) == 0) ? rand_pc() : int'($urandom_range(0, 65535));
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 2) != 0) begin
        pt = m_pred_taken(rpc); ptgt = m_pred_tgt(rpc);
      end else begin
        pt = 1'($urandom_range(0, 1)); ptgt = ($urandom_range(0, 1) == 0) ? rtgt : rand_pc();
      end
      drive_res($urandom_range(0, 3) != 0, rpc, rtgt, int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), kind != 1, kind != 0, pt, ptgt);
      #1;
      total++; if (bp.pred_taken !== m_pred_taken(int'(bp.fetch_pc))) begin bad++; $display("FAIL rnd_pred_taken pc=%h got=%0b want=%0b", bp.fetch_pc, bp.pred_taken, m_pred_taken(int'(bp.fetch_pc))); end
      total++; if (bp.pred_tgt !== 16'(m_pred_tgt(int'(bp.fetch_pc)))) begin bad++; $display("FAIL rnd_pred_tgt pc=%h got=%h want=%h", bp.fetch_pc, bp.pred_tgt, 16'(m_pred_tgt(int'(bp.fetch_pc)))); end
      tick();
      total++; if (bp.mispredict !== m_misp) begin bad++; $display("FAIL rnd_mispredict got=%0b want=%0b", bp.mispredict, m_misp); end
      if (m_misp) begin
        total++; if (bp.redirect_pc !== 16'(m_redir)) begin bad++; $display("FAIL rnd_redirect got=%h want=%h", bp.redirect_pc, 16'(m_redir)); end
      end
      total++; if (bp.branch_count !== m_bc) begin bad++; $display("FAIL rnd_branch_count got=%0d want=%0d", bp.branch_count, m_bc); end
      total++; if (bp.mispredict_count !== m_mc) begin bad++; $display("FAIL rnd_mispredict_count got=%0d want=%0d", bp.mispredict_count, m_mc); end
    end
    rst_n = 1'b1;
    idle_res();
  endtask

  initial begin
    test_reset();
    test_cold_branch();
    test_hysteresis();
    test_jmp_alias();
    test_wrap();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
